dna_uart_report: RTL
====================

# dna_uart_report

Downstream consumer of the FPGA DNA reader. Captures the 57-bit device DNA once it is marked valid and transmits it as an ASCII line over a built-in 8N1 UART transmitter, so a board-test host terminal can log the unique device ID. Sits between the DNA reader output and the board's serial TX pin; no CPU involved.

## Interface
Parameters:
- CLK_HZ, 50_000_000: frequency of clk in Hz.
- BAUD, 115_200: UART bit rate; bit period DIV = floor(CLK_HZ/BAUD) clk cycles, DIV ≥ 2 required.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- dna  input  57  device DNA from the reader, stable while dna_valid is high.
- dna_valid  input  1  high when dna holds the final shifted value; level, may stay high forever.
- resend  input  1  one-cycle pulse requesting a new transmission of the captured value.
- txd  output  1  UART serial output, idle high.
- busy  output  1  high while a message is being transmitted.
- done  output  1  sticky; set when the first complete message finishes, cleared only by rst.

## Operation
- Message is 21 bytes: "DNA=" (0x44 0x4E 0x41 0x3D), 15 uppercase hex digits, CR (0x0D), LF (0x0A).
- Hex digits: dna zero-extended to 60 bits, most significant nibble first; nibble 0–9 → 0x30+n, 10–15 → 0x41+(n−10).
- dna is latched into an internal 57-bit register at message start; later changes of dna do not affect the message in flight.
- States: IDLE, START, DATA, STOP.
  - IDLE: txd=1, busy=0. Start a message when (dna_valid=1 and no message yet sent since reset) or (resend=1 and done=1). On start: latch dna, byte index=0, go START.
  - START: txd=0 for DIV cycles, then DATA with bit index 0.
  - DATA: txd=current byte bit[i], LSB first, DIV cycles per bit; after bit 7 go STOP.
  - STOP: txd=1 for DIV cycles; then if byte index=20 go IDLE, set done, else increment index and go START.
- resend while busy=1 is ignored (not queued). resend before done=1 is ignored.
- dna_valid dropping mid-message does not abort; message completes with latched value.
- Automatic first transmission happens exactly once per reset; further transmissions only via resend.
- Byte generation is combinational from byte index and latched DNA, or a registered lookup; either way, the byte must be stable before its START state begins.

## Timing
- Reset values: txd=1, busy=0, done=0, state IDLE, all counters 0. rst asserted mid-message: on the next clk edge txd=1, busy=0, done=0; the partial byte is abandoned.
- Start latency: trigger sampled high at edge N → busy=1 and txd=0 from edge N+1.
- Each byte occupies exactly 10·DIV cycles; no idle gap between bytes (next start bit begins the cycle after the previous stop bit's last cycle).
- Full message: 210·DIV cycles from first txd falling edge to return to IDLE.
- done and busy=0 change on the same edge that ends the final stop bit.
- Earliest resend accepted: the cycle after busy falls.
- Bit counter wraps to 0 at DIV−1; no cumulative drift (baud error is only the floor of CLK_HZ/BAUD).

## Test plan
- CLK_HZ=8, BAUD=1 (DIV=8), dna=57'h0123456789ABCDE, dna_valid raised at cycle 20 → UART monitor decodes "DNA=0123456789ABCDE\r\n"; busy high for exactly 1680 cycles; done=1 afterwards.
- dna=57'h1FFFFFFFFFFFFFF → digits "1FFFFFFFFFFFFFF"; dna=0 → "000000000000000"; checks MSB nibble zero-extension and A–F uppercase.
- Change dna to 57'h0 at byte 6 of a message with 57'h0123456789ABCDE → still "DNA=0123456789ABCDE\r\n"; then resend pulse → "DNA=000000000000000\r\n".
- resend pulses at cycle 5 (before dna_valid) and mid-message → ignored: exactly one message; dna_valid held high after done → no second message.
- rst asserted at cycle 300 of a message → txd=1, busy=0, done=0 next cycle; after rst release with dna_valid=1 a complete fresh message follows.
- Bit-timing check: every txd transition lands on a multiple of DIV cycles from the first start-bit edge; stop bit high for exactly DIV cycles.

Source files
------------

// File: rtl/dna_uart_report.sv
// dna_uart_report: latches the 57-bit device DNA and sends "DNA=<15 hex>\r\n" over an 8N1 UART.
module dna_uart_report #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [56:0] dna,
  input  logic        dna_valid,
  input  logic        resend,
  output logic        txd,
  output logic        busy,
  output logic        done
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [4:0]    byte_idx;
  logic [56:0]   dna_r;
  logic          sent;
  logic          tick, last, go;
  logic [59:0]   dna_ext;
  logic [3:0]    nib;
  logic [7:0]    hdr_byte, hex_byte, tx_byte;
  assign tick     = cnt == CW'(DIV - 1);
  assign last     = byte_idx == 5'd20;
  assign go       = state == IDLE && ((dna_valid && !sent) || (resend && done));
  assign dna_ext  = {3'b000, dna_r};
  // hex digit k sits at byte k+4, so its nibble shift is 4*(18-byte_idx)
  assign nib      = 4'(dna_ext >> {5'd18 - byte_idx, 2'b00});
  assign hdr_byte = 8'(32'h444E413D >> {~byte_idx[1:0], 3'b000});
  assign hex_byte = nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  assign tx_byte  = byte_idx < 5'd4 ? hdr_byte : byte_idx < 5'd19 ? hex_byte : byte_idx == 5'd19 ? 8'h0D : 8'h0A;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = go ? START : IDLE;
      START: state_nx = tick ? DATA : START;
      DATA:  state_nx = (tick && bit_idx == 3'd7) ? STOP : DATA;
      STOP:  state_nx = tick ? (last ? IDLE : START) : STOP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    txd  = state == START ? 1'b0 : state == DATA ? tx_byte[bit_idx] : 1'b1;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      dna_r    <= '0;
      sent     <= 1'b0;
      done     <= 1'b0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (go) begin
        dna_r    <= dna;
        byte_idx <= '0;
        sent     <= 1'b1;
      end
      if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (state == STOP && tick) begin
        if (last) done <= 1'b1;
        else byte_idx <= byte_idx + 5'd1;
      end
    end
  end
endmodule
